// File: rtl/wb_pkg.sv
// Shared writeback definitions: register index/data widths, queue entry type
// and the helper deciding whether a destination is a real architectural register.
package wb_pkg;

  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 32;
  localparam int NUM_REGS  = 15;
  localparam int PC_IDX    = 15;

  typedef struct packed {
    logic [REG_IDX_W-1:0] dest;
    logic [DATA_W-1:0]    result;
  } wb_entry_t;

  // True when a destination names a general register; the PC index is never
  // written through this port.
  function automatic logic writes_reg(input logic [REG_IDX_W-1:0] dest);
    return (dest != REG_IDX_W'(PC_IDX)) && (int'(dest) < NUM_REGS);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular writeback queue: two ordered push ports (push0 is older), one pop.
// Storage is not reset; occupancy (count) alone says which slots are live.
// With WB_FWD_EN defined the storage and read pointer are exported for forwarding.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push0_valid,
  input  wb_entry_t                push0_entry,
  input  logic                     push1_valid,
  input  wb_entry_t                push1_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count
`ifdef WB_FWD_EN
  ,
  output wb_entry_t                slots [DEPTH],
  output logic [$clog2(DEPTH)-1:0] rd_ptr
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  wb_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] wr_ptr_inc_s;
  logic [1:0]       push_cnt_s;
  logic             pop_s;

  // Number of pushes this cycle, guarded pop, and the slot after the write pointer.
  always_comb begin
    push_cnt_s   = {1'b0, push0_valid} + {1'b0, push1_valid};
    pop_s        = pop && (count_r != {CNT_W{1'b0}});
    wr_ptr_inc_s = wr_ptr_r + PTR_ONE;
  end

  // Storage write: push0 lands first so it drains before push1.
  always_ff @(posedge clk) begin
    if (push0_valid) begin
      mem_r[wr_ptr_r] <= push0_entry;
      if (push1_valid) begin
        mem_r[wr_ptr_inc_s] <= push1_entry;
      end
    end else if (push1_valid) begin
      mem_r[wr_ptr_r] <= push1_entry;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks +pushes-pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_r + PTR_W'(push_cnt_s);
      rd_ptr_r <= rd_ptr_r + PTR_W'(pop_s);
      count_r  <= count_r + CNT_W'(push_cnt_s) - CNT_W'(pop_s);
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

`ifdef WB_FWD_EN
  assign slots  = mem_r;
  assign rd_ptr = rd_ptr_r;
`endif

endmodule

// File: rtl/writeback_buffer.sv
// Writeback buffer: merges ALU and load results into one register-file write
// port through an in-order queue, draining one entry per cycle.
// Optional feature macro: WB_FWD_EN adds two combinational forwarding lookups.
module writeback_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [REG_IDX_W-1:0]   alu_dest,
  input  logic [DATA_W-1:0]      alu_result,
  output logic                   alu_ready,
  input  logic                   mem_valid,
  input  logic [REG_IDX_W-1:0]   mem_dest,
  input  logic [DATA_W-1:0]      mem_result,
  output logic                   mem_ready,
  output logic [REG_IDX_W-1:0]   Dest_wb,
  output logic [DATA_W-1:0]      Result_WB,
  output logic                   writeBackEn,
  output logic [$clog2(DEPTH):0] count
`ifdef WB_FWD_EN
  ,
  input  logic [REG_IDX_W-1:0]   src1,
  input  logic [REG_IDX_W-1:0]   src2,
  output logic                   fwd1_hit,
  output logic                   fwd2_hit,
  output logic [DATA_W-1:0]      fwd1_data,
  output logic [DATA_W-1:0]      fwd2_data
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]     free_s;
  logic                 mem_push_s;
  logic                 alu_push_s;
  logic                 pop_s;
  wb_entry_t            mem_entry_s;
  wb_entry_t            alu_entry_s;
  wb_entry_t            head_s;
  logic                 wb_en_r;
  logic [REG_IDX_W-1:0] dest_r;
  logic [DATA_W-1:0]    result_r;

`ifdef WB_FWD_EN
  localparam int PTR_W = $clog2(DEPTH);
  wb_entry_t            slots_s [DEPTH];
  logic [PTR_W-1:0]     rd_ptr_s;
`endif

  // Ready decode from the registered occupancy; mem needs one free slot, alu
  // needs two so that a simultaneous mem push can never overflow the queue.
  // Transfers to the PC index handshake normally but are dropped here.
  always_comb begin
    free_s      = CNT_W'(DEPTH) - count;
    mem_ready   = (free_s >= CNT_W'(1));
    alu_ready   = (free_s >= CNT_W'(2));
    mem_push_s  = mem_valid && mem_ready && writes_reg(mem_dest);
    alu_push_s  = alu_valid && alu_ready && writes_reg(alu_dest);
    mem_entry_s = '{dest: mem_dest, result: mem_result};
    alu_entry_s = '{dest: alu_dest, result: alu_result};
    pop_s       = (count != {CNT_W{1'b0}});
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push0_valid (mem_push_s),
    .push0_entry (mem_entry_s),
    .push1_valid (alu_push_s),
    .push1_entry (alu_entry_s),
    .pop         (pop_s),
    .head        (head_s),
    .count       (count)
`ifdef WB_FWD_EN
    ,
    .slots       (slots_s),
    .rd_ptr      (rd_ptr_s)
`endif
  );

  // Output stage: register the popped head; hold dest/result when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_r  <= 1'b0;
      dest_r   <= {REG_IDX_W{1'b0}};
      result_r <= {DATA_W{1'b0}};
    end else if (pop_s) begin
      wb_en_r  <= 1'b1;
      dest_r   <= head_s.dest;
      result_r <= head_s.result;
    end else begin
      wb_en_r  <= 1'b0;
    end
  end

  assign writeBackEn = wb_en_r;
  assign Dest_wb     = dest_r;
  assign Result_WB   = result_r;

`ifdef WB_FWD_EN
  logic [REG_IDX_W-1:0] src_s      [2];
  logic                 fwd_hit_s  [2];
  logic [DATA_W-1:0]    fwd_data_s [2];
  logic [PTR_W-1:0]     idx_s;
  logic                 match_s;

  assign src_s[0] = src1;
  assign src_s[1] = src2;

  // Forwarding lookup: the output stage is the oldest candidate, then queued
  // entries from head to tail, so the youngest match is the one kept.
  always_comb begin
    idx_s   = {PTR_W{1'b0}};
    match_s = 1'b0;
    for (int p = 0; p < 2; p++) begin
      match_s       = wb_en_r && (dest_r == src_s[p]);
      fwd_hit_s[p]  = match_s;
      fwd_data_s[p] = match_s ? result_r : {DATA_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        idx_s         = rd_ptr_s + PTR_W'(i);
        match_s       = (CNT_W'(i) < count) && (slots_s[idx_s].dest == src_s[p]);
        fwd_hit_s[p]  = fwd_hit_s[p] || match_s;
        fwd_data_s[p] = match_s ? slots_s[idx_s].result : fwd_data_s[p];
      end
      fwd_hit_s[p] = fwd_hit_s[p] && writes_reg(src_s[p]);
    end
  end

  assign fwd1_hit  = fwd_hit_s[0];
  assign fwd2_hit  = fwd_hit_s[1];
  assign fwd1_data = fwd_data_s[0];
  assign fwd2_data = fwd_data_s[1];
`endif

endmodule

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queued writeback entries (power of two, at least 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports alu_valid input 1, alu_dest input 4, alu_result input 32 and alu_ready output 1: the ALU result source.
REQ-005 SHALL have ports mem_valid input 1, mem_dest input 4, mem_result input 32 and mem_ready output 1: the load-result source.
REQ-006 SHALL have ports Dest_wb output 4, Result_WB output 32 and writeBackEn output 1, which drive the register-file write port.
REQ-007 SHALL have port count  output  $clog2(DEPTH)+1  current queue occupancy.
REQ-008 SHALL, when WB_FWD_EN is defined, have ports src1 and src2 (input 4), fwd1_hit and fwd2_hit (output 1), and fwd1_data and fwd2_data (output 32).

Function
REQ-009 SHALL transfer a source when its valid and ready are both 1 at a rising edge.
REQ-010 SHALL drive ready from the registered count: both readies 1 if free slots >= 2; only mem_ready 1 if free slots == 1; both 0 if full.
REQ-011 SHALL enqueue the mem entry before the alu entry when both transfer in one cycle (mem is older).
REQ-012 SHALL accept and then discard any transfer with dest == 15 (PC), so it never enqueues and never writes.
REQ-013 SHALL pop the head each cycle the queue is non-empty and register it onto Dest_wb/Result_WB with writeBackEn=1 in the next cycle.
REQ-014 SHALL drive writeBackEn 0 in any cycle that follows a cycle with an empty queue, and hold Dest_wb/Result_WB at their last values.
REQ-015 SHALL give a minimum latency of 1 cycle: an entry accepted at edge N into an empty queue appears with writeBackEn=1 after edge N+1.
REQ-016 SHALL allow a push and a pop in the same cycle, with count updated by +pushes-pops.
REQ-017 SHALL wrap the read and write pointers modulo DEPTH.
REQ-018 SHALL preserve write order to the same register: a later entry always writes after an earlier one.

Reset
REQ-019 SHALL on rst clear count, both pointers, writeBackEn, Dest_wb and Result_WB to 0, and drop all queued entries immediately, including mid-drain.
REQ-020 SHALL assert alu_ready=1 and mem_ready=1 in the first cycle after rst deasserts.
REQ-021 SHALL leave the queue storage array unreset; it is masked by count.

Configuration
REQ-022 SHALL, with WB_FWD_EN defined, set fwdN_hit=1 when srcN matches a valid queued entry or the output stage with writeBackEn=1.
REQ-023 SHALL make fwdN_data the youngest queued match, else the output stage, combinationally; srcN == 15 never hits.
REQ-024 SHALL, without WB_FWD_EN, omit the forwarding ports and all their logic.

Structure
REQ-025 SHALL take REG_IDX_W=4, DATA_W=32, NUM_REGS=15, PC_IDX=15 and the typedef wb_entry_t {dest, result} from shared package wb_pkg.
REQ-026 SHALL put the circular queue in one sub-module, wb_fifo (storage, pointers, count, 2-push/1-pop port).

Verification
REQ-027 SHALL cover: alu push dest=3 data=0xDEADBEEF into an empty queue -> next cycle writeBackEn=1, Dest_wb=3, Result_WB=0xDEADBEEF; the cycle after, writeBackEn=0.
REQ-028 SHALL cover: mem (dest=1, 0x11) and alu (dest=1, 0x22) in the same cycle -> writes to reg1 of 0x11 then 0x22 on consecutive cycles.
REQ-029 SHALL cover: holding both sources valid with DEPTH=4 -> when count is 3, mem_ready=1 and alu_ready=0; when count is 4, both readies are 0; no entry is lost.
REQ-030 SHALL cover: alu push dest=15 -> alu_ready=1, count unchanged, writeBackEn stays 0.
REQ-031 SHALL cover: rst asserted with count=3 -> count=0 and writeBackEn=0 immediately; no write of the remaining entries.
REQ-032 SHALL cover, with WB_FWD_EN: queue holds reg5=0xA then reg5=0xB and src1=5 -> fwd1_hit=1, fwd1_data=0xB; src2=15 -> fwd2_hit=0.
